// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_sequencer
//  Description : 2x2 signed matrix multiply, C = A x B, on one time-shared
//                multiplier (8 steps: products accumulated in pairs).
//  Revision    : 1.0
// ============================================================================
module matmul_sequencer #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic              load_sel_ab,
   input  logic [1:0]        load_index,
   input  logic [DATA_W-1:0] in_data,
   input  logic              output_en,
   input  logic [1:0]        output_sel,
   output logic [7:0]        out_data,
   output logic              done,
   output logic              busy
);

   localparam int PW = 2 * DATA_W;

   typedef enum logic [1:0] {
      S_LOAD    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic [7:0] mask_q, mask_d;
   logic [2:0] step_q, step_d;
   logic       wr_en_d;

   logic signed [DATA_W-1:0] a_q [4];
   logic signed [DATA_W-1:0] b_q [4];
   logic signed [ACC_W-1:0]  c_q [4];
   logic signed [ACC_W-1:0]  acc_q;
   logic [7:0]               out_q;
   logic                     done_q;
   logic                     busy_q;

   logic [7:0]               w_bit;
   logic [1:0]               w_e;
   logic                     w_t;
   logic signed [DATA_W-1:0] w_a;
   logic signed [DATA_W-1:0] w_b;
   logic signed [PW-1:0]     w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic                     w_unused_c;

   assign w_bit = 8'b1 << {load_sel_ab, load_index};

   // Step k: e = k>>1 picks the result, t = k&1 picks the inner-product term.
   assign w_e        = step_q[2:1];
   assign w_t        = step_q[0];
   assign w_a        = a_q[{step_q[2], step_q[0]}];
   assign w_b        = b_q[{step_q[0], step_q[1]}];
   assign w_prod     = PW'(w_a) * PW'(w_b);
   assign w_prod_ext = ACC_W'(w_prod);

   assign w_unused_c = ^{c_q[0][ACC_W-1:8], c_q[1][ACC_W-1:8],
                         c_q[2][ACC_W-1:8], c_q[3][ACC_W-1:8]};

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      step_d  = step_q;
      wr_en_d = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (load_en) begin
               wr_en_d = 1'b1;
               mask_d  = mask_q | w_bit;
               if (mask_d == 8'hFF) begin
                  state_d = S_COMPUTE;
                  step_d  = 3'd0;
               end
            end
         end
         S_COMPUTE: begin
            step_d = step_q + 3'd1;
            if (step_q == 3'd7) state_d = S_DONE;
         end
         S_DONE: begin
            if (load_en) begin
               wr_en_d = 1'b1;
               mask_d  = w_bit;
               state_d = S_LOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_LOAD;
         mask_q  <= 8'h00;
         step_q  <= 3'd0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         step_q  <= step_d;
         done_q  <= (state_d == S_DONE);
         busy_q  <= (state_d == S_COMPUTE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            c_q[k] <= '0;
         end
         acc_q <= '0;
         out_q <= 8'h00;
      end else begin
         if (wr_en_d) begin
            if (load_sel_ab) b_q[load_index] <= in_data;
            else             a_q[load_index] <= in_data;
         end
         if (state_q == S_COMPUTE) begin
            if (!w_t) acc_q    <= w_prod_ext;
            else      c_q[w_e] <= acc_q + w_prod_ext;
         end
         if (output_en) out_q <= c_q[output_sel][7:0];
      end
   end

   assign out_data = out_q;
   assign done     = done_q;
   assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_sequencer
//  Description : Directed self-checking bench for matmul_sequencer.
//  Revision    : 1.0
// ============================================================================
module tb_matmul_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load_en = 1'b0;
   logic       load_sel_ab = 1'b0;
   logic [1:0] load_index = 2'd0;
   logic [7:0] in_data = 8'd0;
   logic       output_en = 1'b0;
   logic [1:0] output_sel = 2'd0;
   logic [7:0] out_data;
   logic       done;
   logic       busy;

   int total = 0;
   int bad   = 0;

   matmul_sequencer #(.DATA_W(8), .ACC_W(17)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_en    (load_en),
      .load_sel_ab(load_sel_ab),
      .load_index (load_index),
      .in_data    (in_data),
      .output_en  (output_en),
      .output_sel (output_sel),
      .out_data   (out_data),
      .done       (done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ld(input logic ab, input logic [1:0] idx, input int v);
      load_en     = 1'b1;
      load_sel_ab = ab;
      load_index  = idx;
      in_data     = v[7:0];
      tick();
      load_en     = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [1:0] sel, input logic [7:0] exp);
      output_en  = 1'b1;
      output_sel = sel;
      tick();
      output_en  = 1'b0;
      chk(tag, {24'd0, out_data}, {24'd0, exp});
   endtask

   // Loads A then B; compute must start on the eighth write only.
   task automatic ld8(input string tag, input int a0, input int a1, input int a2, input int a3,
                      input int b0, input int b1, input int b2, input int b3);
      ld(1'b0, 2'd0, a0); ld(1'b0, 2'd1, a1); ld(1'b0, 2'd2, a2); ld(1'b0, 2'd3, a3);
      ld(1'b1, 2'd0, b0); ld(1'b1, 2'd1, b1); ld(1'b1, 2'd2, b2);
      chk({tag, "_busy7"}, {31'd0, busy}, 32'd0);
      ld(1'b1, 2'd3, b3);
      chk({tag, "_busy8"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done(input string tag);
      for (int n = 0; n < 20 && !done; n++) tick();
      chk(tag, {31'd0, done}, 32'd1);
   endtask

   initial begin
      // Reset with random inputs toggling
      rst = 1'b1;
      for (int n = 0; n < 4; n++) begin
         load_en     = 1'($urandom);
         load_sel_ab = 1'($urandom);
         load_index  = 2'($urandom);
         in_data     = 8'($urandom);
         output_en   = 1'($urandom);
         output_sel  = 2'($urandom);
         tick();
      end
      chk("rst_out",  {24'd0, out_data}, 32'h00);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      load_en = 1'b0; output_en = 1'b0;
      rst = 1'b0;
      rd("rst_rd0", 2'd0, 8'h00);
      rd("rst_rd1", 2'd1, 8'h00);
      rd("rst_rd2", 2'd2, 8'h00);
      rd("rst_rd3", 2'd3, 8'h00);

      // Basic product with exact done latency
      ld(1'b0, 2'd0, 1); ld(1'b0, 2'd1, 2); ld(1'b0, 2'd2, 3); ld(1'b0, 2'd3, 4);
      ld(1'b1, 2'd0, 5); ld(1'b1, 2'd1, 6); ld(1'b1, 2'd2, 7);
      chk("basic_busy7", {31'd0, busy}, 32'd0);
      ld(1'b1, 2'd3, 8);
      chk("basic_busy", {31'd0, busy}, 32'd1);
      for (int n = 0; n < 7; n++) tick();
      chk("basic_done7", {31'd0, done}, 32'd0);
      chk("basic_busy_s7", {31'd0, busy}, 32'd1);
      tick();
      chk("basic_done8", {31'd0, done}, 32'd1);
      chk("basic_busy_end", {31'd0, busy}, 32'd0);
      rd("basic_c3", 2'd3, 8'h32);
      rd("basic_c0", 2'd0, 8'h13);
      rd("basic_c1", 2'd1, 8'h16);
      rd("basic_c2", 2'd2, 8'h2B);

      // Reload from DONE with a simultaneous read
      output_en  = 1'b1;
      output_sel = 2'd0;
      ld(1'b0, 2'd0, -1);
      output_en  = 1'b0;
      chk("reload_rd", {24'd0, out_data}, 32'h13);
      chk("reload_done", {31'd0, done}, 32'd0);
      rd("reload_prior_c3", 2'd3, 8'h32);
      ld(1'b0, 2'd1, 0); ld(1'b0, 2'd2, 0); ld(1'b0, 2'd3, -1);
      ld(1'b1, 2'd0, 5); ld(1'b1, 2'd1, -3); ld(1'b1, 2'd2, 7);
      chk("signed_busy7", {31'd0, busy}, 32'd0);
      ld(1'b1, 2'd3, 2);
      chk("signed_busy8", {31'd0, busy}, 32'd1);
      wait_done("signed_done");
      rd("signed_c0", 2'd0, 8'hFB);
      rd("signed_c1", 2'd1, 8'h03);
      rd("signed_c2", 2'd2, 8'hF9);
      rd("signed_c3", 2'd3, 8'hFE);

      // Extremes: (-128*-128)*2 = 32768, low byte 0
      ld8("ext", -128, -128, -128, -128, -128, -128, -128, -128);
      wait_done("ext_done");
      rd("ext_c0", 2'd0, 8'h00);
      rd("ext_c1", 2'd1, 8'h00);
      rd("ext_c2", 2'd2, 8'h00);
      rd("ext_c3", 2'd3, 8'h00);

      // Load rules: overwrite does not start compute, busy writes ignored
      ld(1'b0, 2'd0, 9);
      ld(1'b0, 2'd1, 2); ld(1'b0, 2'd2, 3); ld(1'b0, 2'd3, 4);
      ld(1'b1, 2'd0, 5); ld(1'b1, 2'd1, 6); ld(1'b1, 2'd2, 7);
      ld(1'b0, 2'd0, 1);
      chk("rules_overwrite_busy", {31'd0, busy}, 32'd0);
      ld(1'b1, 2'd3, 8);
      chk("rules_start", {31'd0, busy}, 32'd1);
      ld(1'b0, 2'd0, 100);
      ld(1'b1, 2'd0, 50);
      rd("rules_rd_busy", 2'd3, 8'h00);
      wait_done("rules_done");
      rd("rules_c0", 2'd0, 8'h13);
      rd("rules_c1", 2'd1, 8'h16);
      rd("rules_c2", 2'd2, 8'h2B);
      rd("rules_c3", 2'd3, 8'h32);

      // Reset mid-compute at step 4
      ld8("mid", 2, -3, 1, 5, 4, 1, -2, 6);
      for (int n = 0; n < 4; n++) tick();
      rst = 1'b1;
      #2;
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_out",  {24'd0, out_data}, 32'h00);
      tick();
      rst = 1'b0;
      ld8("mid_reload", 2, -3, 1, 5, 4, 1, -2, 6);
      wait_done("mid_done");
      rd("mid_c0", 2'd0, 8'h0E);
      rd("mid_c1", 2'd1, 8'hF0);
      rd("mid_c2", 2'd2, 8'hFA);
      rd("mid_c3", 2'd3, 8'h1F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
